ws2812_rx: RTL



---
 rtl/ws2812_pkg.sv | 31 +++
 rtl/ws2812_edge_sync.sv | 32 +++
 rtl/ws2812_rx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// Shared WS2812 protocol definitions: bit timings, FSM encodings, GRB field layout.
// The ns-to-cycle helper lets each side derive its thresholds from its own clock.
package ws2812_pkg;

    localparam int T0H_NS      = 400;
    localparam int T1H_NS      = 800;
    localparam int PERIOD_NS   = 1250;
    localparam int LATCH_NS    = 50_000;
    localparam int MAX_HIGH_NS = 1500;

    // Decision point between a short (0) and a long (1) high pulse.
    localparam int THRESH_NS   = (T0H_NS + T1H_NS) / 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_ERR  = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    function automatic int ns_to_cyc(input longint clk_hz, input longint ns);
        return int'((clk_hz * ns) / 64'sd1_000_000_000);
    endfunction

endpackage

// File: rtl/ws2812_edge_sync.sv
// Two-flop synchroniser for the asynchronous serial line, plus registered
// rise/fall pulses that are cycle-aligned with the delayed level output.
module ws2812_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;

    // Flops reset high so a line already high out of reset yields no rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            lvl  <= 1'b1;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            lvl  <= s2;
            rise <= s2 & ~lvl;
            fall <= ~s2 & lvl;
        end
    end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: measures high-pulse widths, assembles MSB-first GRB pixels,
// and reports latch gaps (frame ends) and protocol errors.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int MAIN_CLK   = 12_000_000,
    parameter int MAX_PIXELS = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WS2812_DIN,
    output logic [23:0] PIXEL,
    output logic        PIXEL_VALID,
    output logic [7:0]  PIXEL_INDEX,
    output logic        FRAME_END,
    output logic [7:0]  FRAME_PIXELS,
    output logic        ERROR
);

    localparam int HIGH_THRESH = ns_to_cyc(MAIN_CLK, THRESH_NS);
    localparam int MAX_HIGH    = ns_to_cyc(MAIN_CLK, MAX_HIGH_NS);
    localparam int RESET_CYC   = ns_to_cyc(MAIN_CLK, LATCH_NS);
    localparam int CNT_W       = $clog2(RESET_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TH_LIM   = CNT_W'(HIGH_THRESH);
    localparam logic [CNT_W-1:0] HI_LIM   = CNT_W'(MAX_HIGH - 1);
    localparam logic [CNT_W-1:0] LO_LIM   = CNT_W'(RESET_CYC - 1);
    localparam logic [7:0]       PIX_MAX  = 8'(MAX_PIXELS);

    logic            lvl;
    logic            rise;
    logic            fall;
    rx_state_e       state_q;
    rx_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    grb_t            shift_q;
    logic [4:0]      bit_cnt_q;
    logic [7:0]      pix_cnt_q;

    logic take_bit;
    logic new_bit;
    logic pix_done;
    logic hi_over;
    logic frame_done;
    logic err_done;

    ws2812_edge_sync u_sync (
        .clk  (CLK),
        .rst  (RST),
        .din  (WS2812_DIN),
        .lvl  (lvl),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (rise) state_d = ST_HIGH;
            ST_HIGH: begin
                if (hi_over)   state_d = ST_ERR;
                else if (fall) state_d = ST_LOW;
            end
            ST_LOW: begin
                if (rise)            state_d = ST_HIGH;
                else if (frame_done) state_d = ST_IDLE;
            end
            ST_ERR: if (err_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The counter is loaded with 1 on each edge so it counts the sample that
    // carried the edge; at a falling edge it therefore holds the full high width.
    always_comb begin
        take_bit   = (state_q == ST_HIGH) && fall;
        new_bit    = (cnt_q >= TH_LIM);
        pix_done   = take_bit && (bit_cnt_q == 5'd23);
        hi_over    = (state_q == ST_HIGH) && lvl && (cnt_q == HI_LIM);
        frame_done = (state_q == ST_LOW) && !lvl && (cnt_q == LO_LIM);
        err_done   = (state_q == ST_ERR) && !lvl && (cnt_q == LO_LIM);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            PIXEL        <= '0;
            PIXEL_VALID  <= 1'b0;
            PIXEL_INDEX  <= '0;
            FRAME_END    <= 1'b0;
            FRAME_PIXELS <= '0;
            ERROR        <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: cnt_q <= rise ? CNT_ONE : '0;
                ST_HIGH: begin
                    if (fall)         cnt_q <= CNT_ONE;
                    else if (hi_over) cnt_q <= '0;
                    else              cnt_q <= cnt_q + CNT_ONE;
                end
                ST_LOW: begin
                    if (rise)            cnt_q <= CNT_ONE;
                    else if (frame_done) cnt_q <= '0;
                    else                 cnt_q <= cnt_q + CNT_ONE;
                end
                ST_ERR: begin
                    if (lvl || err_done) cnt_q <= '0;
                    else                 cnt_q <= cnt_q + CNT_ONE;
                end
                default: cnt_q <= '0;
            endcase

            if (take_bit) begin
                shift_q   <= {shift_q[22:0], new_bit};
                bit_cnt_q <= pix_done ? 5'd0 : bit_cnt_q + 5'd1;
            end else if (hi_over || frame_done || err_done) begin
                bit_cnt_q <= '0;
            end

            // An aborted frame (error recovery) restarts pixel numbering too.
            if (frame_done || err_done)
                pix_cnt_q <= '0;
            else if (pix_done && (pix_cnt_q != PIX_MAX))
                pix_cnt_q <= pix_cnt_q + 8'd1;

            PIXEL_VALID <= pix_done;
            if (pix_done) begin
                PIXEL       <= {shift_q[22:0], new_bit};
                PIXEL_INDEX <= pix_cnt_q;
            end

            FRAME_END <= frame_done;
            if (frame_done)
                FRAME_PIXELS <= pix_cnt_q;

            ERROR <= hi_over || (frame_done && (bit_cnt_q != 5'd0));
        end
    end

endmodule
